// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int STRB_W     = 4;
  localparam int DATA_W     = 8 * WORD_BYTES;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0001_0000;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle between CPU MEM stage and responder
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              req_we;
  logic [STRB_W-1:0] req_strb;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_strb, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_strb, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_sram_array.sv
// rtl/dmem_sram_array.sv - single-port byte-writable word array with registered read
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [STRB_W-1:0]     strb,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Read register only moves on an enabled load so the response word stays put while it waits
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem_q[addr];
    end
  end

  // Byte-lane writes; a zero strobe leaves the word untouched
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb[b]) begin
          mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data register (array contents and this register are never reset)
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder; DMEM_ERR_EN enables range/alignment errors
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 14,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic           clk,
  input  logic           rst,
  dmem_responder_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rd_sel_q, rd_sel_d;

  logic                  req_ready_c;
  logic                  enter_resp;
  logic [31:0]           req_off;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_err;
  logic                  sram_en;
  logic                  sram_we;
  logic [DATA_W-1:0]     sram_rdata;

  // Offset from the window base; the word index simply drops the byte bits and wraps
  assign req_off = bus.req_addr - BASE_ADDR;
  assign req_idx = req_off[DEPTH_LOG2+1:2];

`ifdef DMEM_ERR_EN
  assign req_err = (req_off >= (32'd4 << DEPTH_LOG2)) || (bus.req_addr[1:0] != 2'b00);
`else
  logic unused_req_off;
  assign unused_req_off = ^{req_off[31:DEPTH_LOG2+2], req_off[1:0]};
  assign req_err        = 1'b0;
`endif

  // Next-state logic; commit operands are taken from the _d copies so a zero-wait
  // request commits straight from the bus on its acceptance edge
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    we_d        = we_q;
    strb_d      = strb_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_err_d   = rsp_err_q;
    rd_sel_d    = rd_sel_q;
    req_ready_c = 1'b0;
    enter_resp  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          idx_d   = req_idx;
          we_d    = bus.req_we;
          strb_d  = bus.req_strb;
          wdata_d = bus.req_wdata;
          err_d   = req_err;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d   = ST_IDLE;
          rsp_err_d = 1'b0;
          rd_sel_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_resp) begin
      rsp_err_d = err_d;
      rd_sel_d  = !we_d && !err_d;
    end
  end

  // A reset on the commit edge must not touch the array
  assign sram_en = enter_resp && !rst;
  assign sram_we = we_d && !err_d;

  dmem_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (idx_d),
    .strb (strb_d),
    .wdata(wdata_d),
    .rdata(sram_rdata)
  );

  // State and latched-request registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rsp_err_q <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rsp_err_q <= rsp_err_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rd_sel_q ? sram_rdata : '0;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized model-checked bench for dmem_responder
module tb_dmem_responder;

  localparam int          W     = 2;
  localparam int          DEPTH = 14;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_LOG2 (DEPTH),
    .WAIT_CYCLES(W),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem   [0:(1<<DEPTH)-1];
  bit          m_known [0:(1<<DEPTH)-1];
  bit          m_busy = 0;
  bit          m_committed = 0;
  int          m_age = 0;
  logic [31:0] m_exp_rdata = 0;
  bit          m_exp_err = 0;
  bit          m_exp_known = 0;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_strb;
  logic        p_we;

  task automatic model_commit();
    logic [31:0] off;
    int          idx;
    bit          err;
    off = p_addr - BASE;
    idx = int'((off >> 2) % (32'd1 << DEPTH));
    err = 0;
`ifdef DMEM_ERR_EN
    err = (off >= (32'd4 << DEPTH)) || (p_addr[1:0] != 2'b00);
`endif
    m_committed = 1;
    m_exp_err   = err;
    if (p_we || err) begin
      m_exp_rdata = 32'h0;
      m_exp_known = 1;
      if (p_we && !err) begin
        for (int b = 0; b < 4; b++)
          if (p_strb[b]) m_mem[idx][8*b +: 8] = p_wdata[8*b +: 8];
        if (p_strb == 4'hF) m_known[idx] = 1;
      end
    end else begin
      m_exp_rdata = m_mem[idx];
      m_exp_known = m_known[idx];
    end
  endtask

  // Model advances on each rising edge from the handshake rules
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_committed = 0;
    end else if (m_busy && m_committed) begin
      if (bus.rsp_ready) begin
        m_busy = 0;
        m_committed = 0;
      end
    end else if (m_busy) begin
      m_age++;
      if (m_age == W) model_commit();
    end else if (bus.req_valid) begin
      m_busy  = 1;
      m_age   = 0;
      p_addr  = bus.req_addr;
      p_we    = bus.req_we;
      p_strb  = bus.req_strb;
      p_wdata = bus.req_wdata;
      if (W == 0) model_commit();
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("req_ready", {31'b0, bus.req_ready}, {31'b0, !m_busy});
      chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_busy && m_committed});
      if (m_busy && m_committed) begin
        chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, m_exp_err});
        if (m_exp_known) chk("rsp_rdata", bus.rsp_rdata, m_exp_rdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    bit   acc = 0;
    int   n = 0;
    logic rdy;
    bus.req_addr  = a;
    bus.req_we    = w;
    bus.req_strb  = s;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    while (!acc && n < 40) begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      n++;
      if (rdy === 1'b1) acc = 1;
    end
    #1 bus.req_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int hold, output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid === 1'b1) seen = 1;
    end
    lat = n;
    rd  = bus.rsp_rdata;
    er  = bus.rsp_err;
    if (!seen) chk("rsp_timeout", 32'd0, 32'd1);
    if (hold == 0) begin
      @(posedge clk);
      #1;
    end else begin
      repeat (hold) @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic txn(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                     input int hold, output logic [31:0] rd, output logic er, output int lat);
    bus.rsp_ready = (hold == 0);
    issue(a, w, s, d);
    wait_rsp(hold, rd, er, lat);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd, rd0, ra, rdat;
  logic        er;
  int          lat;

  initial begin
    bus.req_valid = 0;
    bus.req_addr  = 0;
    bus.req_we    = 0;
    bus.req_strb  = 0;
    bus.req_wdata = 0;
    bus.rsp_ready = 0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
    chk_en = 1;
    @(posedge clk);
    #1;

    // store then load, latency pinned
    txn(32'h0001_0010, 1, 4'hF, 32'hDEADBEEF, 0, rd, er, lat);
    chk("store_latency", lat, 32'd3);
    chk("store_rdata_zero", rd, 32'd0);
    txn(32'h0001_0010, 0, 4'h0, 32'h0, 0, rd, er, lat);
    chk("load_latency", lat, 32'd3);
    chk("load_deadbeef", rd, 32'hDEADBEEF);

    // byte-lane store
    txn(32'h0001_0010, 1, 4'b0010, 32'h0000_AA00, 0, rd, er, lat);
    txn(32'h0001_0010, 0, 4'h0, 32'h0, 0, rd, er, lat);
    chk("load_byte_merge", rd, 32'hDEADAAEF);

    // backpressure with a held request behind it
    bus.rsp_ready = 0;
    issue(32'h0001_0010, 0, 4'h0, 32'h0);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 32'd3);
    rd0 = bus.rsp_rdata;
    @(posedge clk);
    #1;
    bus.req_addr  = 32'h0001_0010;
    bus.req_we    = 0;
    bus.req_strb  = 0;
    bus.req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_stable", {31'b0, bus.rsp_valid}, 32'd1);
      chk("bp_rdata_stable", bus.rsp_rdata, 32'hDEADAAEF);
      chk("bp_held_not_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    chk("bp_first_rdata", rd0, 32'hDEADAAEF);
    @(posedge clk);
    #1 bus.rsp_ready = 1;
    @(negedge clk);
    chk("bp_ready_before_hs", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1 bus.rsp_ready = 0;
    @(negedge clk);
    chk("bp_ready_after_idle", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 0;
    bus.rsp_ready = 1;
    wait_rsp(0, rd, er, lat);
    chk("held_req_latency", lat, 32'd3);
    chk("held_req_rdata", rd, 32'hDEADAAEF);

    // reset while busy aborts a store
    txn(32'h0001_0020, 1, 4'hF, 32'h1111_2222, 0, rd, er, lat);
    bus.rsp_ready = 1;
    issue(32'h0001_0020, 1, 4'hF, 32'h9999_8888);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    txn(32'h0001_0020, 0, 4'h0, 32'h0, 0, rd, er, lat);
    chk("abort_old_data", rd, 32'h1111_2222);

    // error / wrap behaviour on word 0
    txn(32'h0001_0000, 1, 4'hF, 32'hCAFE_0001, 0, rd, er, lat);
    txn(32'h0001_0003, 0, 4'h0, 32'h0, 0, rd, er, lat);
`ifdef DMEM_ERR_EN
    chk("misaligned_err", {31'b0, er}, 32'd1);
    chk("misaligned_rdata", rd, 32'd0);
    txn(32'h0000_0000, 1, 4'hF, 32'h5555_5555, 0, rd, er, lat);
    chk("range_err", {31'b0, er}, 32'd1);
    chk("range_err_latency", lat, 32'd3);
    txn(32'h0001_0000, 0, 4'h0, 32'h0, 0, rd, er, lat);
    chk("range_no_write", rd, 32'hCAFE_0001);
`else
    chk("unaligned_reads_word0", rd, 32'hCAFE_0001);
    chk("unaligned_no_err", {31'b0, er}, 32'd0);
`endif

    // fill a small window, then random traffic over it
    for (int w = 0; w < 16; w++)
      txn(BASE + 32'(w * 4), 1, 4'hF, $urandom, 0, rd, er, lat);
    for (int t = 0; t < 200; t++) begin
      int kind;
      ra   = BASE + 32'($urandom_range(0, 15) * 4);
      kind = $urandom_range(0, 9);
      if (kind == 0) ra = ra + 32'h0001_0000;
      else if (kind == 1) ra = ra + 32'($urandom_range(1, 3));
      rdat = $urandom;
      txn(ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rdat,
          $urandom_range(0, 3), rd, er, lat);
      chk("rand_latency", lat, W + 1);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
